// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared FSM state encoding and default sizes for the register bank arbiter
package reg_bank_pkg;
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RELEASE = 2'd2
    } state_t;
    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = 2;
endpackage

// File: rtl/dff_word.sv
// dff_word: one bank register with load enable and asynchronous active-low clear
module dff_word #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // hold the stored word, loading d only when enabled
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin shared access to a small register bank, one op per grant
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       we,
    input  logic [N_REQ*AW-1:0]    addr,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic                   ack,
    output logic [WIDTH-1:0]       rdata,
    output logic                   busy
);
    localparam int IW = $clog2(N_REQ);
    state_t state;
    logic [IW-1:0] ptr, win, win_c, j;
    logic hit;
    logic lat_we;
    logic [AW-1:0] lat_addr;
    logic [WIDTH-1:0] lat_wdata, rd_c;
    logic [WIDTH-1:0] bank_q [DEPTH];
    assign busy = state != S_IDLE;
    // round-robin search starting just after the last winner
    always_comb begin
        win_c = '0;
        hit   = 1'b0;
        j     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = IW'((int'(ptr) + k) % N_REQ);
            if (!hit && req[j]) begin
                hit   = 1'b1;
                win_c = j;
            end
        end
    end
    // read mux; addresses with no backing register read as zero
    always_comb begin
        rd_c = '0;
        for (int k = 0; k < DEPTH; k++)
            if (lat_addr == AW'(k)) rd_c = bank_q[k];
    end
    for (genvar g = 0; g < DEPTH; g++) begin : g_bank
        dff_word #(.WIDTH(WIDTH)) u_word (
            .clk   (clk),
            .reset (reset),
            .en    (state == S_ACCESS && lat_we && lat_addr == AW'(g)),
            .d     (lat_wdata),
            .q     (bank_q[g])
        );
    end
    // grant, perform one access, then hold the grant until the winner lets go
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state     <= S_IDLE;
            ptr       <= IW'(N_REQ - 1);
            win       <= '0;
            gnt       <= '0;
            ack       <= 1'b0;
            rdata     <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                S_IDLE:
                    if (hit) begin
                        win       <= win_c;
                        gnt       <= N_REQ'(1) << win_c;
                        lat_we    <= we[win_c];
                        lat_addr  <= addr[win_c*AW +: AW];
                        lat_wdata <= wdata[win_c*WIDTH +: WIDTH];
                        state     <= S_ACCESS;
                    end
                S_ACCESS: begin
                    ack   <= 1'b1;
                    rdata <= lat_we ? rdata : rd_c;
                    state <= S_RELEASE;
                end
                S_RELEASE: begin
                    ack <= 1'b0;
                    if (!req[win]) begin
                        gnt   <= '0;
                        ptr   <= win;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: randomized and directed checks against a behavioural bank/arbiter model
module tb_reg_bank_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] req = '0, we = '0;
    logic [7:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0] gnt, gnt3;
    logic ack, ack3, busy, busy3;
    logic [7:0] rdata, rdata3;
    int checks = 0, failures = 0;
    int m_ptr;
    logic [7:0] m_bank [4];
    logic op_we [4];
    int op_a [4];
    logic [7:0] op_d [4];

    always #5 clk = ~clk;

    reg_bank_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy)
    );
    reg_bank_arbiter #(.DEPTH(3), .AW(2)) dut3 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt3), .ack(ack3), .rdata(rdata3), .busy(busy3)
    );

    function automatic int exp_winner(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        return 0;
    endfunction

    task automatic set_op(input int r, input logic w, input int a, input logic [7:0] d);
        we[r] = w;
        addr[r*2 +: 2] = 2'(a);
        wdata[r*8 +: 8] = d;
        op_we[r] = w;
        op_a[r] = a;
        op_d[r] = d;
    endtask

    task automatic model_commit(input int r);
        if (op_we[r]) m_bank[op_a[r]] = op_d[r];
        m_ptr = r;
    endtask

    task automatic do_reset();
        req = '0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_ptr = 3;
        for (int i = 0; i < 4; i++) m_bank[i] = '0;
    endtask

    // drive one transaction to completion from a negedge, returning observations only
    task automatic serve(input int hold, output logic [3:0] g, output logic [7:0] rd,
                         output logic [7:0] rd3, output bit ack_ok, output bit held_ok,
                         output bit rel_ok);
        int lat = 0;
        while (gnt === 4'b0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        g = gnt;
        ack_ok = (lat == 1) && (ack === 1'b0);
        @(negedge clk);
        ack_ok = ack_ok && (ack === 1'b1) && (ack3 === 1'b1);
        rd = rdata;
        rd3 = rdata3;
        held_ok = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (gnt !== g || ack !== 1'b0) held_ok = 1'b0;
        end
        req = req & ~g;
        @(negedge clk);
        rel_ok = gnt === 4'b0 && ack === 1'b0 && busy === 1'b0 && gnt3 === 4'b0 && busy3 === 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] g;
        logic [7:0] rd, rd3;
        bit a_ok, h_ok, r_ok;
        do_reset();
        checks++;
        if (gnt !== 4'b0 || ack !== 1'b0 || busy !== 1'b0 || rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_state gnt=%b ack=%b busy=%b rdata=%h want 0", gnt, ack, busy, rdata);
        end
        set_op(1, 1'b1, 2, 8'h77);
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL reset_pre_grant gnt=%b want 0010", gnt);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0 || ack !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_async gnt=%b ack=%b busy=%b want 0", gnt, ack, busy);
        end
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        m_ptr = 3;
        for (int i = 0; i < 4; i++) m_bank[i] = '0;
        for (int a = 0; a < 4; a++) begin
            set_op(0, 1'b0, a, 8'h00);
            req = 4'b0001;
            serve(0, g, rd, rd3, a_ok, h_ok, r_ok);
            checks++;
            if (g !== 4'b0001 || rd !== 8'h00 || !a_ok || !r_ok) begin
                failures++;
                $display("FAIL reset_clear addr=%0d gnt=%b rdata=%h ack_ok=%b rel_ok=%b want 0001/00", a, g, rd, a_ok, r_ok);
            end
            model_commit(0);
        end
    endtask

    task automatic test_single();
        logic [3:0] g;
        logic [7:0] rd, rd3;
        bit a_ok, h_ok, r_ok;
        set_op(2, 1'b1, 3, 8'hA5);
        req = 4'b0100;
        serve(1, g, rd, rd3, a_ok, h_ok, r_ok);
        checks++;
        if (g !== 4'b0100 || !a_ok || !h_ok || !r_ok) begin
            failures++;
            $display("FAIL single_write gnt=%b ack_ok=%b held_ok=%b rel_ok=%b want 0100/1/1/1", g, a_ok, h_ok, r_ok);
        end
        model_commit(2);
        set_op(2, 1'b0, 3, 8'h00);
        req = 4'b0100;
        serve(0, g, rd, rd3, a_ok, h_ok, r_ok);
        checks++;
        if (g !== 4'b0100 || rd !== 8'hA5 || !a_ok) begin
            failures++;
            $display("FAIL single_read gnt=%b rdata=%h ack_ok=%b want 0100/a5/1", g, rd, a_ok);
        end
        model_commit(2);
    endtask

    task automatic test_contention();
        logic [3:0] g, e;
        logic [7:0] rd, rd3;
        bit a_ok, h_ok, r_ok;
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int r = 0; r < 4; r++) set_op(r, 1'b0, r, 8'h00);
        for (int i = 0; i < 5; i++) begin
            req = 4'b1111;
            e = 4'b0001 << order[i];
            serve(2, g, rd, rd3, a_ok, h_ok, r_ok);
            checks++;
            if (g !== e || !a_ok || !h_ok || !r_ok) begin
                failures++;
                $display("FAIL contention_%0d gnt=%b ack_ok=%b held_ok=%b rel_ok=%b want %b", i, g, a_ok, h_ok, r_ok, e);
            end
            model_commit(order[i]);
        end
    endtask

    task automatic test_early_drop();
        logic [3:0] g;
        logic [7:0] rd, rd3;
        bit a_ok, h_ok, r_ok;
        set_op(1, 1'b1, 0, 8'h3C);
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL early_grant gnt=%b want 0010", gnt);
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL early_ack ack=%b want 1", ack);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0 || ack !== 1'b0) begin
            failures++;
            $display("FAIL early_idle busy=%b gnt=%b ack=%b want 0", busy, gnt, ack);
        end
        model_commit(1);
        set_op(2, 1'b0, 0, 8'h00);
        req = 4'b0100;
        serve(0, g, rd, rd3, a_ok, h_ok, r_ok);
        checks++;
        if (g !== 4'b0100 || rd !== 8'h3C || !a_ok) begin
            failures++;
            $display("FAIL early_readback gnt=%b rdata=%h want 0100/3c", g, rd);
        end
        model_commit(2);
    endtask

    task automatic test_ignored();
        set_op(0, 1'b1, 1, 8'h5A);
        set_op(3, 1'b0, 1, 8'h00);
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL ignored_grant0 gnt=%b want 0001", gnt);
        end
        @(negedge clk);
        req = 4'b1001;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL ignored_busy gnt=%b want 0001", gnt);
        end
        req = 4'b1000;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_idle gnt=%b busy=%b want 0/0", gnt, busy);
        end
        model_commit(0);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b1000) begin
            failures++;
            $display("FAIL ignored_grant3 gnt=%b want 1000", gnt);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b1 || rdata !== m_bank[1]) begin
            failures++;
            $display("FAIL ignored_read ack=%b rdata=%h want 1/%h", ack, rdata, m_bank[1]);
        end
        req = 4'b0000;
        @(negedge clk);
        model_commit(3);
    endtask

    task automatic test_depth3();
        logic [3:0] g;
        logic [7:0] rd, rd3;
        bit a_ok, h_ok, r_ok;
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        do_reset();
        for (int a = 0; a < 3; a++) begin
            set_op(0, 1'b1, a, vals[a]);
            req = 4'b0001;
            serve(0, g, rd, rd3, a_ok, h_ok, r_ok);
            model_commit(0);
        end
        set_op(0, 1'b1, 3, 8'hFF);
        req = 4'b0001;
        serve(0, g, rd, rd3, a_ok, h_ok, r_ok);
        checks++;
        if (!a_ok || !r_ok) begin
            failures++;
            $display("FAIL depth3_write_ack ack_ok=%b rel_ok=%b want 1/1", a_ok, r_ok);
        end
        model_commit(0);
        set_op(0, 1'b0, 3, 8'h00);
        req = 4'b0001;
        serve(0, g, rd, rd3, a_ok, h_ok, r_ok);
        checks++;
        if (rd3 !== 8'h00 || rd !== 8'hFF || !a_ok) begin
            failures++;
            $display("FAIL depth3_read_oob rdata3=%h rdata=%h want 00/ff", rd3, rd);
        end
        model_commit(0);
        for (int a = 0; a < 3; a++) begin
            set_op(0, 1'b0, a, 8'h00);
            req = 4'b0001;
            serve(0, g, rd, rd3, a_ok, h_ok, r_ok);
            checks++;
            if (rd3 !== vals[a]) begin
                failures++;
                $display("FAIL depth3_unchanged addr=%0d rdata3=%h want %h", a, rd3, vals[a]);
            end
            model_commit(0);
        end
    endtask

    task automatic test_random();
        logic [3:0] g, e, rv;
        logic [7:0] rd, rd3;
        bit a_ok, h_ok, r_ok;
        int w;
        for (int i = 0; i < 60; i++) begin
            rv = 4'($urandom_range(1, 15));
            for (int r = 0; r < 4; r++)
                set_op(r, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 8'($urandom));
            w = exp_winner(rv, m_ptr);
            e = 4'b0001 << w;
            req = rv;
            serve($urandom_range(0, 2), g, rd, rd3, a_ok, h_ok, r_ok);
            checks++;
            if (g !== e || !a_ok || !h_ok || !r_ok) begin
                failures++;
                $display("FAIL random_%0d req=%b gnt=%b ack_ok=%b held_ok=%b rel_ok=%b want %b", i, rv, g, a_ok, h_ok, r_ok, e);
            end
            if (!op_we[w]) begin
                checks++;
                if (rd !== m_bank[op_a[w]]) begin
                    failures++;
                    $display("FAIL random_read_%0d addr=%0d rdata=%h want %h", i, op_a[w], rd, m_bank[op_a[w]]);
                end
            end
            model_commit(w);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_early_drop();
        test_ignored();
        test_random();
        test_depth3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
